uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver; counterpart of the team's uart_tx.
- Samples a single data line, reassembles LSB-first frames and checks optional parity and 1 or 2 stop bits.
- Presents each received byte with a one-cycle valid strobe and per-frame error flags.
- Sits between the board RX pin and the consumer logic.

Parameters:
- p_clk_speed_hz, 50_000_000, system clock frequency in Hz.
- p_baud_rate, 9_600, line bit rate.
- Derived: CYC = p_clk_speed_hz / p_baud_rate. One bit period is CYC+1 clocks, matching uart_tx timing. Mid-bit offset HALF = (CYC+1)/2, integer division.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  1  serial line, asynchronous to clk_i; idle level is high.
- parity_en_i  in  1  1 = a parity bit follows the data bits.
- parity_sel_i  in  1  1 = expected parity bit is ^data; 0 = expected parity bit is ~^data (same rule as uart_tx).
- stop_sel_i  in  1  0 = one stop bit; 1 = two stop bits.
- data_o  out  8  last received byte.
- data_valid_o  out  1  one-cycle strobe: data_o and the error flags are updated.
- parity_err_o  out  1  parity mismatch in the last frame.
- frame_err_o  out  1  a stop bit was sampled low in the last frame.
- busy_o  out  1  frame reception in progress (state != IDLE).

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, synchroniser flops = 1, data_o = 0, data_valid_o = 0, parity_err_o = 0, frame_err_o = 0, counters = 0.
- Reset asserted mid-frame aborts the frame immediately; no valid strobe is produced.
- Input synchroniser: 2 flops on data_i. Every decision uses the synchronised line rx_s, which lags the pin by 2 cycles.
- Config latch: parity_en_i, parity_sel_i and stop_sel_i are latched on the IDLE->START transition. Changes mid-frame have no effect.
- Cycle counter: counts 0..CYC, then wraps. Cleared on every state transition and while in IDLE.
- IDLE: if rx_s == 0, go to START and latch config.
- START: at count HALF, check rx_s.
  - rx_s == 1: glitch; return to IDLE, no flags changed.
  - rx_s == 0: clear counter and go to DATA; all later samples land at bit centres.
- DATA: at each count CYC, shift rx_s into bit[bit_cnt], LSB first.
  - After bit 7: go to PARITY if parity is enabled, otherwise STOP.
- PARITY: at count CYC, sample the parity bit and compare it with the expected value from parity_sel.
- STOP: at count CYC, sample the stop bit. A sample of 0 sets the internal frame error.
  - With stop_sel = 1, the second stop bit is sampled one period later. A low on either stop bit sets frame error.
- Completion, in the cycle after the final stop sample:
  - data_valid_o = 1 for exactly one cycle.
  - data_o, parity_err_o and frame_err_o are loaded together.
  - parity_err_o = 0 when parity is disabled.
  - Next state: IDLE if there is no frame error, otherwise BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. A line held low therefore yields exactly one frame_err strobe, not repeated frames.
- Holding: data_o and the error flags hold until the next data_valid_o. There is no consumer back-pressure; a byte not taken before the next strobe is lost.
- Back-to-back frames: a start edge detected in the cycle IDLE is entered must be accepted with no dead cycles.
- Latency: the valid strobe occurs 2 (synchroniser) + HALF + (n_bits × (CYC+1)) + 1 cycles after the start edge at the pin. n_bits counts the data, parity and stop bits sampled.
- States: IDLE, START, DATA, PARITY, STOP, BREAK. Encoding is 3 bits. Undefined encodings return to IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit sample is the majority of rx_s at count C-1, C and C+1, where C is the normal sample point. The decision is made at C+1, so every decision shifts 1 cycle later and the valid strobe arrives 1 cycle later. The START glitch check also uses the vote. Requires CYC >= 4.
- Undefined: single sample at C.

Test Plan:
- p_clk_speed_hz=1_000_000, p_baud_rate=100_000 (period 11 clocks), no parity, 1 stop, send 0xA5 via uart_tx -> one data_valid_o pulse, data_o=0xA5, both error flags 0.
- Parity enabled, parity_sel=1, bytes 0x00, 0x01, 0xFF -> all received, parity_err_o=0. Force a corrupted parity bit on 0x01 -> parity_err_o=1, data_o=0x01.
- stop_sel=1, byte 0x3C with the second stop bit driven low -> frame_err_o=1, then exactly one strobe; line held low 30 bit times -> no further strobes until the line goes high.
- 3-clock low pulse on data_i while idle -> stays IDLE, no strobe, busy_o returns to 0 within HALF+3 cycles.
- Stream 0x11, 0x22, 0x33 back-to-back from uart_tx, with random config changes mid-frame -> three strobes with the correct bytes.
- rst_n_i asserted in the middle of DATA -> outputs cleared asynchronously; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first asynchronous receiver with optional parity and 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to vote each sample over three clocks (requires CYC >= 4).
module uart_rx #(
   parameter int unsigned p_clk_speed_hz = 50_000_000,
   parameter int unsigned p_baud_rate    = 9_600
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       data_i,
   input  logic       parity_en_i,
   input  logic       parity_sel_i,
   input  logic       stop_sel_i,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned Cyc  = p_clk_speed_hz / p_baud_rate;
   localparam int unsigned Half = (Cyc + 1) / 2;
   localparam int unsigned CntW = (Cyc < 2) ? 1 : $clog2(Cyc + 1);

   localparam logic [CntW-1:0] CntMax = CntW'(Cyc);
`ifdef UART_RX_MAJORITY_EN
   // The vote needs the sample after the centre, so the start check moves one clock later
   // and every later sample inherits that shift through the counter clear.
   localparam logic [CntW-1:0] StartPt = CntW'(Half + 1);
`else
   localparam logic [CntW-1:0] StartPt = CntW'(Half);
`endif

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StBreak  = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic            bit_s;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_en_q, par_en_d;
   logic            par_sel_q, par_sel_d;
   logic            stop_sel_q, stop_sel_d;
   logic            stop2_q, stop2_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            perr_out_q, perr_out_d;
   logic            ferr_out_q, ferr_out_d;
   logic            exp_par;
   logic            ferr_final;

   assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign bit_s = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign bit_s = rx_s;
`endif

   assign exp_par    = par_sel_q ? ^shift_q : ~^shift_q;
   assign ferr_final = ferr_q | ~bit_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_sel_d  = par_sel_q;
      stop_sel_d = stop_sel_q;
      stop2_d    = stop2_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d    = StStart;
               par_en_d   = parity_en_i;
               par_sel_d  = parity_sel_i;
               stop_sel_d = stop_sel_i;
            end
         end
         StStart: begin
            if (cnt_q == StartPt) begin
               if (bit_s) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  bit_cnt_d = '0;
                  stop2_d   = 1'b0;
                  perr_d    = 1'b0;
                  ferr_d    = 1'b0;
               end
            end
         end
         StData: begin
            if (cnt_q == CntMax) begin
               shift_d   = {bit_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = par_en_q ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (cnt_q == CntMax) begin
               perr_d  = (bit_s != exp_par);
               state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == CntMax) begin
               if (stop_sel_q && !stop2_q) begin
                  stop2_d = 1'b1;
                  ferr_d  = ferr_final;
               end else begin
                  valid_d    = 1'b1;
                  data_d     = shift_q;
                  perr_out_d = par_en_q & perr_q;
                  ferr_out_d = ferr_final;
                  // A low stop bit may be a held-low line; wait for idle before rearming.
                  state_d    = ferr_final ? StBreak : StIdle;
               end
            end
         end
         StBreak: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         sync_q     <= 2'b11;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_sel_q  <= 1'b0;
         stop_sel_q <= 1'b0;
         stop2_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], data_i};
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_sel_q  <= par_sel_d;
         stop_sel_q <= stop_sel_d;
         stop2_q    <= stop2_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign parity_err_o = perr_out_q;
   assign frame_err_o  = ferr_out_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged frames compared against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned ClkHz = 1_000_000;
   localparam int unsigned Baud  = 100_000;
   localparam int unsigned Bit   = ClkHz / Baud + 1;
   localparam int unsigned Half  = Bit / 2;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       data_i = 1'b1;
   logic       parity_en_i = 1'b0;
   logic       parity_sel_i = 1'b0;
   logic       stop_sel_i = 1'b0;
   logic [7:0] data_o;
   logic       data_valid_o;
   logic       parity_err_o;
   logic       frame_err_o;
   logic       busy_o;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } rec_t;

   rec_t obs_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   uart_rx #(
      .p_clk_speed_hz(ClkHz),
      .p_baud_rate   (Baud)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .data_i      (data_i),
      .parity_en_i (parity_en_i),
      .parity_sel_i(parity_sel_i),
      .stop_sel_i  (stop_sel_i),
      .data_o      (data_o),
      .data_valid_o(data_valid_o),
      .parity_err_o(parity_err_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   always #500 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (data_valid_o) obs_q.push_back('{data: data_o, perr: parity_err_o, ferr: frame_err_o});
   end

   initial begin
      #60_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Parity bit a transmitter emits: sel=1 -> 1 when the count of ones is odd.
   function automatic logic par_bit(input logic [7:0] b, input logic sel);
      int  ones = 0;
      logic odd;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      odd = (ones % 2) == 1;
      return sel ? odd : !odd;
   endfunction

   function automatic rec_t model(input logic [7:0] b, input logic pe, input logic bad,
                                  input logic two, input logic s1_low, input logic s2_low);
      rec_t r;
      r.data = b;
      r.perr = pe & bad;
      r.ferr = s1_low | (two & s2_low);
      return r;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      data_i = b;
      wait_clks(Bit);
   endtask

   task automatic wait_strobes(input int n);
      for (int i = 0; i < 4 * Bit && obs_q.size() < n; i++) wait_clks(1);
   endtask

   // Leaves the line at the level of the last stop bit.
   task automatic send_frame(input logic [7:0] b, input logic pe, input logic ps,
                             input logic two, input logic bad, input logic s1_low,
                             input logic s2_low, input logic scramble);
      parity_en_i  = pe;
      parity_sel_i = ps;
      stop_sel_i   = two;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(b[i]);
         if (scramble && i == 1) begin
            parity_en_i  = 1'($urandom);
            parity_sel_i = 1'($urandom);
            stop_sel_i   = 1'($urandom);
         end
      end
      if (pe) drive_bit(par_bit(b, ps) ^ bad);
      drive_bit(!s1_low);
      if (two) drive_bit(!s2_low);
   endtask

   task automatic test_reset;
      wait_clks(3);
      n_checks++;
      if ({data_o, data_valid_o, parity_err_o, frame_err_o, busy_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b busy=%b, expected all 0",
                  data_o, data_valid_o, parity_err_o, frame_err_o, busy_o);
      end
      rst_n_i = 1'b1;
      wait_clks(3);
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b, expected 0", busy_o);
      end
   endtask

   task automatic test_basic;
      rec_t exp_r;
      obs_q.delete();
      send_frame(8'hA5, 0, 0, 0, 0, 0, 0, 0);
      wait_strobes(1);
      wait_clks(2);
      exp_r = model(8'hA5, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_q.size() !== 1) begin
         n_fail++;
         $display("FAIL basic_count: got %0d strobes, expected 1", obs_q.size());
      end
      if (obs_q.size() > 0) begin
         n_checks++;
         if (obs_q[0] !== exp_r) begin
            n_fail++;
            $display("FAIL basic_frame: got %h/%b/%b, expected %h/%b/%b", obs_q[0].data,
                     obs_q[0].perr, obs_q[0].ferr, exp_r.data, exp_r.perr, exp_r.ferr);
         end
      end
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy: got %b, expected 0", busy_o);
      end
      n_checks++;
      if (data_o !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_hold: got %h, expected a5", data_o);
      end
   endtask

   task automatic test_parity;
      logic [7:0] bytes[4];
      logic       bads[4];
      rec_t       exp_r, got;
      bytes = '{8'h00, 8'h01, 8'hFF, 8'h01};
      bads  = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         obs_q.delete();
         send_frame(bytes[k], 1, 1, 0, bads[k], 0, 0, 0);
         wait_strobes(1);
         exp_r = model(bytes[k], 1, bads[k], 0, 0, 0);
         n_checks++;
         if (obs_q.size() !== 1) begin
            n_fail++;
            $display("FAIL parity_count[%0d]: got %0d strobes, expected 1", k, obs_q.size());
         end else begin
            got = obs_q.pop_front();
            n_checks++;
            if (got !== exp_r) begin
               n_fail++;
               $display("FAIL parity_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", k, got.data,
                        got.perr, got.ferr, exp_r.data, exp_r.perr, exp_r.ferr);
            end
         end
         wait_clks(2);
      end
   endtask

   task automatic test_break;
      rec_t exp_r, got;
      obs_q.delete();
      send_frame(8'h3C, 0, 0, 1, 0, 0, 1, 0);
      wait_strobes(1);
      exp_r = model(8'h3C, 0, 0, 1, 0, 1);
      n_checks++;
      if (obs_q.size() !== 1) begin
         n_fail++;
         $display("FAIL break_count: got %0d strobes, expected 1", obs_q.size());
      end else begin
         got = obs_q.pop_front();
         n_checks++;
         if (got !== exp_r) begin
            n_fail++;
            $display("FAIL break_frame: got %h/%b/%b, expected %h/%b/%b", got.data, got.perr,
                     got.ferr, exp_r.data, exp_r.perr, exp_r.ferr);
         end
      end
      wait_clks(30 * Bit);
      n_checks++;
      if (busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL break_busy_low: got %b, expected 1", busy_o);
      end
      data_i = 1'b1;
      wait_clks(2 * Bit);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL break_extra: got %0d extra strobes, expected 0", obs_q.size());
      end
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL break_release: got busy %b, expected 0", busy_o);
      end
   endtask

   task automatic test_glitch;
      obs_q.delete();
      data_i = 1'b0;
      wait_clks(3);
      data_i = 1'b1;
      n_checks++;
      if (busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_seen: got busy %b, expected 1", busy_o);
      end
      wait_clks(Half + 3);
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_idle: got busy %b, expected 0", busy_o);
      end
      wait_clks(2 * Bit);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL glitch_strobe: got %0d strobes, expected 0", obs_q.size());
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes[3];
      rec_t       exp_q[$];
      rec_t       got;
      logic       pe, ps, two;
      bytes = '{8'h11, 8'h22, 8'h33};
      obs_q.delete();
      for (int k = 0; k < 3; k++) begin
         pe  = 1'($urandom);
         ps  = 1'($urandom);
         two = 1'($urandom);
         exp_q.push_back(model(bytes[k], pe, 0, two, 0, 0));
         send_frame(bytes[k], pe, ps, two, 0, 0, 0, 1);
      end
      wait_strobes(3);
      n_checks++;
      if (obs_q.size() !== 3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d strobes, expected 3", obs_q.size());
      end
      for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
         got = obs_q.pop_front();
         n_checks++;
         if (got !== exp_q[k]) begin
            n_fail++;
            $display("FAIL b2b_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", k, got.data,
                     got.perr, got.ferr, exp_q[k].data, exp_q[k].perr, exp_q[k].ferr);
         end
      end
   endtask

   task automatic test_random;
      logic [7:0] b;
      logic       pe, ps, two, bad, s1, s2;
      rec_t       exp_r, got;
      for (int k = 0; k < 24; k++) begin
         obs_q.delete();
         b   = 8'($urandom);
         pe  = 1'($urandom);
         ps  = 1'($urandom);
         two = 1'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         s1  = ($urandom_range(0, 5) == 0);
         s2  = ($urandom_range(0, 5) == 0);
         exp_r = model(b, pe, bad, two, s1, s2);
         wait_clks($urandom_range(0, 3));
         send_frame(b, pe, ps, two, bad, s1, s2, 1);
         wait_strobes(1);
         n_checks++;
         if (obs_q.size() !== 1) begin
            n_fail++;
            $display("FAIL rand_count[%0d]: got %0d strobes, expected 1", k, obs_q.size());
         end else begin
            got = obs_q.pop_front();
            n_checks++;
            if (got !== exp_r) begin
               n_fail++;
               $display("FAIL rand_frame[%0d]: got %h/%b/%b, expected %h/%b/%b", k, got.data,
                        got.perr, got.ferr, exp_r.data, exp_r.perr, exp_r.ferr);
            end
         end
         if (s1 || s2) drive_bit(1'b1);
         data_i = 1'b1;
      end
   endtask

   task automatic test_reset_mid;
      rec_t exp_r, got;
      obs_q.delete();
      send_frame(8'hC3, 0, 0, 0, 0, 0, 0, 0);
      wait_strobes(1);
      wait_clks(2);
      obs_q.delete();
      data_i = 1'b0;
      wait_clks(Bit);
      for (int i = 0; i < 3; i++) drive_bit(i[0]);
      wait_clks(4);
      n_checks++;
      if (busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_busy_before: got %b, expected 1", busy_o);
      end
      #300;
      rst_n_i = 1'b0;
      #100;
      n_checks++;
      if ({data_o, data_valid_o, parity_err_o, frame_err_o, busy_o} !== 12'h000) begin
         n_fail++;
         $display("FAIL rstmid_clear: got data=%h v=%b pe=%b fe=%b busy=%b, expected all 0",
                  data_o, data_valid_o, parity_err_o, frame_err_o, busy_o);
      end
      data_i = 1'b1;
      wait_clks(2);
      rst_n_i = 1'b1;
      wait_clks(2 * Bit);
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rstmid_abort: got %0d strobes, expected 0", obs_q.size());
      end
      send_frame(8'h5A, 0, 0, 0, 0, 0, 0, 0);
      wait_strobes(1);
      exp_r = model(8'h5A, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_q.size() !== 1) begin
         n_fail++;
         $display("FAIL rstmid_count: got %0d strobes, expected 1", obs_q.size());
      end else begin
         got = obs_q.pop_front();
         n_checks++;
         if (got !== exp_r) begin
            n_fail++;
            $display("FAIL rstmid_frame: got %h/%b/%b, expected %h/%b/%b", got.data, got.perr,
                     got.ferr, exp_r.data, exp_r.perr, exp_r.ferr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
